// File: rtl/cordic_pkg.sv
// Shared constants for the rotation and vectoring CORDIC pipelines: widths, the
// arctangent table (LSB = 2*pi/2^23) and the inverse CORDIC gain in Q0.20.
package cordic_pkg;

   localparam int IN_W     = 20;
   localparam int XY_W     = 22;
   localparam int Z_W      = 23;
   localparam int MAG_W    = 21;
   localparam int KINV_W   = 20;
   localparam int MAX_ITER = 16;

   typedef logic signed [XY_W-1:0] xy_t;
   typedef logic        [Z_W-1:0]  z_t;

   localparam z_t               ANG_PI = 23'h400000;
   localparam logic [KINV_W-1:0] K_INV = 20'd636751;

   // atan(2^-k) scaled so that a full turn is 2^23.
   localparam z_t ATAN [0:MAX_ITER-1] = '{
      23'd1048576, 23'd619011, 23'd327068, 23'd166025,
      23'd83335,   23'd41708,  23'd20859,  23'd10430,
      23'd5215,    23'd2608,   23'd1304,   23'd652,
      23'd326,     23'd163,    23'd81,     23'd41
   };

   function automatic z_t atan_at(input int unsigned k);
      z_t r;
      if (k < MAX_ITER) begin
         r = ATAN[k];
      end else begin
         r = {Z_W{1'b0}};
      end
      return r;
   endfunction

endpackage

// File: rtl/cordic_vector_stage.sv
// One registered vectoring micro-rotation: drives y toward zero and
// accumulates the applied rotation angle in z.
module cordic_vector_stage
   import cordic_pkg::*;
(
   input  logic       iclk,
   input  logic       ireset,
   input  logic       inCS,
   input  logic       ivalid,
   input  logic [3:0] ishift,
   input  z_t         iatan,
   input  xy_t        ix,
   input  xy_t        iy,
   input  z_t         iz,
   output xy_t        ox,
   output xy_t        oy,
   output z_t         oz,
   output logic       ovalid
);

   xy_t  x_d, x_q, y_d, y_q;
   xy_t  x_sh_s, y_sh_s;
   z_t   z_d, z_q;
   logic valid_d, valid_q;

   // Micro-rotation toward the x axis; a zero vector keeps its angle at the pre-rotation value.
   always_comb begin
      x_sh_s  = ix >>> ishift;
      y_sh_s  = iy >>> ishift;
      valid_d = ivalid;
      x_d     = ix;
      y_d     = iy;
      z_d     = iz;
      if ((ix == 22'sd0) && (iy == 22'sd0)) begin
         x_d = ix;
         y_d = iy;
         z_d = iz;
      end else if (!iy[XY_W-1]) begin
         x_d = ix + y_sh_s;
         y_d = iy - x_sh_s;
         z_d = iz + iatan;
      end else begin
         x_d = ix - y_sh_s;
         y_d = iy + x_sh_s;
         z_d = iz - iatan;
      end
   end

   // Stage register: reset wins, chip select high freezes.
   always_ff @(posedge iclk) begin
      if (ireset) begin
         x_q     <= {XY_W{1'b0}};
         y_q     <= {XY_W{1'b0}};
         z_q     <= {Z_W{1'b0}};
         valid_q <= 1'b0;
      end else if (!inCS) begin
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         valid_q <= valid_d;
      end
   end

   assign ox     = x_q;
   assign oy     = y_q;
   assign oz     = z_q;
   assign ovalid = valid_q;

endmodule

// File: rtl/cordic_vector_pipelined.sv
// Pipelined vectoring CORDIC: (x, y) -> (magnitude, angle), one sample per enabled clock.
// Define CORDIC_VECTOR_GAIN_COMP_EN to add a registered 1/K gain-compensation stage.
module cordic_vector_pipelined
   import cordic_pkg::*;
#(
   parameter int ITERATIONS = 16
) (
   input  logic                   iclk,
   input  logic                   ireset,
   input  logic                   inCS,
   input  logic                   ivalid,
   input  logic signed [IN_W-1:0] ix,
   input  logic signed [IN_W-1:0] iy,
   output logic                   ovalid,
   output logic [MAG_W-1:0]       omag,
   output logic [Z_W-1:0]         oangle
);

   xy_t  ix_ext_s, iy_ext_s;
   xy_t  x0_d, x0_q, y0_d, y0_q;
   z_t   z0_d, z0_q;
   logic v0_d, v0_q;

   xy_t  x_s [0:ITERATIONS];
   xy_t  y_s [0:ITERATIONS];
   z_t   z_s [0:ITERATIONS];
   logic v_s [0:ITERATIONS];

   // Fold the left half-plane onto the right one and preload z with -pi.
   always_comb begin
      ix_ext_s = {{(XY_W-IN_W){ix[IN_W-1]}}, ix};
      iy_ext_s = {{(XY_W-IN_W){iy[IN_W-1]}}, iy};
      v0_d     = ivalid;
      if (ix[IN_W-1]) begin
         x0_d = -ix_ext_s;
         y0_d = -iy_ext_s;
         z0_d = ANG_PI;
      end else begin
         x0_d = ix_ext_s;
         y0_d = iy_ext_s;
         z0_d = {Z_W{1'b0}};
      end
   end

   // Pre-rotation register.
   always_ff @(posedge iclk) begin
      if (ireset) begin
         x0_q <= {XY_W{1'b0}};
         y0_q <= {XY_W{1'b0}};
         z0_q <= {Z_W{1'b0}};
         v0_q <= 1'b0;
      end else if (!inCS) begin
         x0_q <= x0_d;
         y0_q <= y0_d;
         z0_q <= z0_d;
         v0_q <= v0_d;
      end
   end

   assign x_s[0] = x0_q;
   assign y_s[0] = y0_q;
   assign z_s[0] = z0_q;
   assign v_s[0] = v0_q;

   for (genvar k = 0; k < ITERATIONS; k++) begin : g_stage
      cordic_vector_stage u_stage (
         .iclk   (iclk),
         .ireset (ireset),
         .inCS   (inCS),
         .ivalid (v_s[k]),
         .ishift (4'(k)),
         .iatan  (atan_at(k)),
         .ix     (x_s[k]),
         .iy     (y_s[k]),
         .iz     (z_s[k]),
         .ox     (x_s[k+1]),
         .oy     (y_s[k+1]),
         .oz     (z_s[k+1]),
         .ovalid (v_s[k+1])
      );
   end

`ifdef CORDIC_VECTOR_GAIN_COMP_EN
   logic [MAG_W+KINV_W-1:0] prod_s;
   logic [MAG_W-1:0]        mag_d, mag_q;
   z_t                      ang_d, ang_q;
   logic                    vout_d, vout_q;
   logic                    unused_s;

   // Scale by 1/K; the product of a 21-bit magnitude and 0.607 in Q0.20 fits 41 bits.
   always_comb begin
      prod_s = (MAG_W+KINV_W)'(x_s[ITERATIONS][MAG_W-1:0]) * (MAG_W+KINV_W)'(K_INV);
      mag_d  = prod_s[MAG_W+KINV_W-1:KINV_W];
      ang_d  = z_s[ITERATIONS];
      vout_d = v_s[ITERATIONS];
   end

   // Gain stage register; the angle rides along to stay aligned.
   always_ff @(posedge iclk) begin
      if (ireset) begin
         mag_q  <= {MAG_W{1'b0}};
         ang_q  <= {Z_W{1'b0}};
         vout_q <= 1'b0;
      end else if (!inCS) begin
         mag_q  <= mag_d;
         ang_q  <= ang_d;
         vout_q <= vout_d;
      end
   end

   assign omag     = mag_q;
   assign oangle   = ang_q;
   assign ovalid   = vout_q;
   assign unused_s = ^{y_s[ITERATIONS], x_s[ITERATIONS][XY_W-1], prod_s[KINV_W-1:0]};
`else
   logic unused_s;

   assign omag     = x_s[ITERATIONS][MAG_W-1:0];
   assign oangle   = z_s[ITERATIONS];
   assign ovalid   = v_s[ITERATIONS];
   assign unused_s = ^{y_s[ITERATIONS], x_s[ITERATIONS][XY_W-1]};
`endif

endmodule

// File: tb/tb_cordic_vector_pipelined.sv
// Directed and streaming bench for cordic_vector_pipelined; results are compared
// against hand-computed vectors and an ideal floating-point polar conversion.
module tb_cordic_vector_pipelined;

`ifdef CORDIC_VECTOR_GAIN_COMP_EN
   localparam int  LAT  = 18;
   localparam real GAIN = 1.0;
`else
   localparam int  LAT  = 17;
   localparam real GAIN = 1.6467602578;
`endif
   localparam real PI_R    = 3.14159265358979;
   localparam int  ANG_TOL = 64;
   localparam int  MAG_TOL = 16;

   logic               iclk = 1'b0;
   logic               ireset, inCS, ivalid;
   logic signed [19:0] ix, iy;
   logic               ovalid;
   logic [20:0]        omag;
   logic [22:0]        oangle;

   int n_checks = 0;
   int n_fail   = 0;
   int en_cnt   = 0;
   int obs_mag[$], obs_ang[$], obs_t[$];
   int exp_mag[$], exp_ang[$], exp_t[$];

   always #5 iclk = ~iclk;

   cordic_vector_pipelined dut (
      .iclk   (iclk),
      .ireset (ireset),
      .inCS   (inCS),
      .ivalid (ivalid),
      .ix     (ix),
      .iy     (iy),
      .ovalid (ovalid),
      .omag   (omag),
      .oangle (oangle)
   );

   // Record each result with the index of the enabled clock that produced it.
   always @(posedge iclk) begin : monitor
      logic cs_s;
      cs_s = inCS;
      #1;
      if (cs_s === 1'b0) begin
         en_cnt++;
         if (ovalid === 1'b1) begin
            obs_mag.push_back(int'(omag));
            obs_ang.push_back(int'(oangle));
            obs_t.push_back(en_cnt);
         end
      end
   end

   function automatic int model_mag(input int x, input int y);
      return int'($floor($sqrt(real'(x) * real'(x) + real'(y) * real'(y)) * GAIN + 0.5));
   endfunction

   function automatic int model_ang(input int x, input int y);
      real a;
      a = $atan2(real'(y), real'(x));
      return int'($floor(a * 4194304.0 / PI_R + 0.5));
   endfunction

   function automatic int ang_dist(input int a, input int b);
      logic signed [22:0] d;
      d = 23'(a - b);
      return (d < 0) ? -int'(d) : int'(d);
   endfunction

   function automatic int abs_i(input int a);
      return (a < 0) ? -a : a;
   endfunction

   task automatic drive(input logic v, input int x, input int y, input logic cs,
                        input logic rst, input int m, input int a);
      @(negedge iclk);
      ivalid = v;
      ix     = 20'(x);
      iy     = 20'(y);
      inCS   = cs;
      ireset = rst;
      if (v && !cs && !rst) begin
         exp_mag.push_back(m);
         exp_ang.push_back(a);
         exp_t.push_back(en_cnt + LAT);
      end
   endtask

   task automatic send_model(input int x, input int y);
      drive(1'b1, x, y, 1'b0, 1'b0, model_mag(x, y), model_ang(x, y));
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
   endtask

   task automatic clear_q();
      obs_mag.delete(); obs_ang.delete(); obs_t.delete();
      exp_mag.delete(); exp_ang.delete(); exp_t.delete();
   endtask

   task automatic test_reset();
      @(posedge iclk); #1;
      n_checks += 3;
      if (ovalid !== 1'b0) begin n_fail++; $display("FAIL reset1_valid: got %b want 0", ovalid); end
      if (omag !== 21'd0) begin n_fail++; $display("FAIL reset1_mag: got %0d want 0", omag); end
      if (oangle !== 23'd0) begin n_fail++; $display("FAIL reset1_ang: got %0d want 0", oangle); end
      drive(1'b1, 5555, 6666, 1'b0, 1'b1, 0, 0);
      @(posedge iclk); #1;
      n_checks += 3;
      if (ovalid !== 1'b0) begin n_fail++; $display("FAIL reset2_valid: got %b want 0", ovalid); end
      if (omag !== 21'd0) begin n_fail++; $display("FAIL reset2_mag: got %0d want 0", omag); end
      if (oangle !== 23'd0) begin n_fail++; $display("FAIL reset2_ang: got %0d want 0", oangle); end
      clear_q();
      idle(LAT + 3);
      n_checks += 4;
      if (obs_mag.size() != 0) begin n_fail++; $display("FAIL reset_ghost: got %0d outputs want 0", obs_mag.size()); end
      if (ovalid !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid: got %b want 0", ovalid); end
      if (omag !== 21'd0) begin n_fail++; $display("FAIL post_reset_mag: got %0d want 0", omag); end
      if (oangle !== 23'd0) begin n_fail++; $display("FAIL post_reset_ang: got %0d want 0", oangle); end
   endtask

   task automatic test_directed();
      int tx [7] = '{100000, 0, 0, -100000, -524288, -100000, 0};
      int ty [7] = '{0, 100000, -100000, -100000, 0, 0, 0};
`ifdef CORDIC_VECTOR_GAIN_COMP_EN
      int tm [7] = '{100000, 100000, 100000, 141421, 524288, 100000, 0};
`else
      int tm [7] = '{164676, 164676, 164676, 232886, 863376, 164676, 0};
`endif
      int ta [7] = '{0, 2097152, 6291456, 5242880, 4194304, 4194304, 0};
      for (int i = 0; i < 7; i++) begin
         clear_q();
         drive(1'b1, tx[i], ty[i], 1'b0, 1'b0, tm[i], ta[i]);
         idle(LAT + 3);
         n_checks++;
         if (obs_mag.size() != 1) begin
            n_fail++;
            $display("FAIL dir%0d_count: got %0d outputs want 1", i, obs_mag.size());
         end else begin
            n_checks += 3;
            if (obs_t[0] != exp_t[0]) begin n_fail++; $display("FAIL dir%0d_latency: got clk %0d want %0d", i, obs_t[0], exp_t[0]); end
            if (abs_i(obs_mag[0] - exp_mag[0]) > MAG_TOL) begin n_fail++; $display("FAIL dir%0d_mag: got %0d want %0d", i, obs_mag[0], exp_mag[0]); end
            if (ang_dist(obs_ang[0], exp_ang[0]) > ANG_TOL) begin n_fail++; $display("FAIL dir%0d_ang: got %0d want %0d", i, obs_ang[0], exp_ang[0]); end
         end
      end
   endtask

   task automatic test_stream();
      int x, y;
      clear_q();
      for (int i = 0; i < 40; i++) begin
         if (i % 5 == 4) begin
            idle(1);
         end else begin
            x = int'($urandom_range(0, 1048575)) - 524288;
            y = int'($urandom_range(0, 1048575)) - 524288;
            if (abs_i(x) < 150000 && abs_i(y) < 150000) x = (x < 0) ? -300000 : 300000;
            send_model(x, y);
         end
      end
      idle(LAT + 3);
      n_checks++;
      if (obs_mag.size() != exp_mag.size() || exp_mag.size() != 32) begin
         n_fail++;
         $display("FAIL stream_count: got %0d outputs want %0d", obs_mag.size(), exp_mag.size());
      end
      for (int i = 0; i < obs_mag.size() && i < exp_mag.size(); i++) begin
         n_checks += 3;
         if (obs_t[i] != exp_t[i]) begin n_fail++; $display("FAIL stream%0d_time: got clk %0d want %0d", i, obs_t[i], exp_t[i]); end
         if (abs_i(obs_mag[i] - exp_mag[i]) > MAG_TOL) begin n_fail++; $display("FAIL stream%0d_mag: got %0d want %0d", i, obs_mag[i], exp_mag[i]); end
         if (ang_dist(obs_ang[i], exp_ang[i]) > ANG_TOL) begin n_fail++; $display("FAIL stream%0d_ang: got %0d want %0d", i, obs_ang[i], exp_ang[i]); end
      end
   endtask

   task automatic test_stall();
      logic        snap_v;
      logic [20:0] snap_m;
      logic [22:0] snap_a;
      clear_q();
      for (int i = 0; i < 20; i++) send_model(200000 + i * 9000, -150000 + i * 13000);
      @(posedge iclk); #1;
      snap_v = ovalid; snap_m = omag; snap_a = oangle;
      for (int s = 0; s < 5; s++) begin
         drive(1'b1, 400000, -400000, 1'b1, 1'b0, 0, 0);
         @(posedge iclk); #1;
         n_checks += 3;
         if (ovalid !== snap_v) begin n_fail++; $display("FAIL stall%0d_valid: got %b want %b", s, ovalid, snap_v); end
         if (omag !== snap_m) begin n_fail++; $display("FAIL stall%0d_mag: got %0d want %0d", s, omag, snap_m); end
         if (oangle !== snap_a) begin n_fail++; $display("FAIL stall%0d_ang: got %0d want %0d", s, oangle, snap_a); end
      end
      for (int i = 0; i < 10; i++) send_model(-250000 + i * 7000, 180000 - i * 31000);
      idle(LAT + 3);
      n_checks++;
      if (obs_mag.size() != exp_mag.size() || exp_mag.size() != 30) begin
         n_fail++;
         $display("FAIL stall_count: got %0d outputs want %0d", obs_mag.size(), exp_mag.size());
      end
      for (int i = 0; i < obs_mag.size() && i < exp_mag.size(); i++) begin
         n_checks += 3;
         if (obs_t[i] != exp_t[i]) begin n_fail++; $display("FAIL stallres%0d_time: got clk %0d want %0d", i, obs_t[i], exp_t[i]); end
         if (abs_i(obs_mag[i] - exp_mag[i]) > MAG_TOL) begin n_fail++; $display("FAIL stallres%0d_mag: got %0d want %0d", i, obs_mag[i], exp_mag[i]); end
         if (ang_dist(obs_ang[i], exp_ang[i]) > ANG_TOL) begin n_fail++; $display("FAIL stallres%0d_ang: got %0d want %0d", i, obs_ang[i], exp_ang[i]); end
      end
   endtask

   task automatic test_reset_midflight();
      clear_q();
      for (int i = 0; i < 10; i++) send_model(300000 - i * 20000, 100000 + i * 15000);
      exp_mag.delete(); exp_ang.delete(); exp_t.delete();
      drive(1'b1, 111111, 22222, 1'b0, 1'b1, 0, 0);
      @(posedge iclk); #1;
      n_checks++;
      if (ovalid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b want 0", ovalid); end
      send_model(200000, 100000);
      idle(LAT + 3);
      n_checks++;
      if (obs_mag.size() != 1) begin
         n_fail++;
         $display("FAIL midreset_count: got %0d outputs want 1", obs_mag.size());
      end else begin
         n_checks += 3;
         if (obs_t[0] != exp_t[0]) begin n_fail++; $display("FAIL midreset_latency: got clk %0d want %0d", obs_t[0], exp_t[0]); end
         if (abs_i(obs_mag[0] - exp_mag[0]) > MAG_TOL) begin n_fail++; $display("FAIL midreset_mag: got %0d want %0d", obs_mag[0], exp_mag[0]); end
         if (ang_dist(obs_ang[0], exp_ang[0]) > ANG_TOL) begin n_fail++; $display("FAIL midreset_ang: got %0d want %0d", obs_ang[0], exp_ang[0]); end
      end
   endtask

   initial begin
      ireset = 1'b1;
      inCS   = 1'b0;
      ivalid = 1'b1;
      ix     = 20'sd12345;
      iy     = 20'sd777;
      test_reset();
      test_directed();
      test_stream();
      test_stall();
      test_reset_midflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cordic_vector_pipelined.md
# cordic_vector_pipelined

Pipelined CORDIC in vectoring mode: converts a Cartesian vector (x, y) to polar form (magnitude, angle). It is the inverse of the pipelined rotation CORDIC and shares that block's angle format and arctangent table. Each pipeline stage registers one iteration, and the block accepts one sample per enabled clock. The block sits after sample acquisition and feeds phase and amplitude consumers.

## Interface
- ITERATIONS, 16, number of micro-rotation stages; legal range 8..16.
- iclk  input  1  clock; all logic is on the rising edge.
- ireset  input  1  synchronous, active-high reset.
- inCS  input  1  active-low chip select; when high, every pipeline register holds its value.
- ivalid  input  1  input sample qualifier.
- ix  input  20  signed two's-complement x.
- iy  input  20  signed two's-complement y.
- ovalid  output  1  output qualifier; pulses once per accepted sample.
- omag  output  21  unsigned magnitude.
- oangle  output  23  signed angle; LSB = 2π/2^23, so 0x200000 = π/2 and 0x400000 = −π; range [−π, π).

## Operation
- **Stage 0 (pre-rotation):**
  - Sign-extend ix and iy to 22 bits.
  - If ix < 0: x0 = −ix, y0 = −iy, z0 = 0x400000. Otherwise x0 = ix, y0 = iy, z0 = 0.
  - ix = −2^19 negates to +2^19 without overflow in 22 bits.
- **Stage k (k = 0..ITERATIONS−1):**
  - If y ≥ 0: x += y>>>k, y −= x>>>k, z += ATAN[k].
  - Otherwise: x −= y>>>k, y += x>>>k, z −= ATAN[k].
  - Shifts are arithmetic. Both x and y updates use the previous-stage values.
- **Widths:**
  - x and y are 22-bit signed; z is 23-bit, wrapping modulo 2^23.
  - Wrap is intended: a −π offset plus an in-range residual yields the correct angle.
- **Output:** omag = final x[20:0], which is always ≥ 0 and below 2^21. oangle = final z.
- **Gain:** without compensation, omag = K·|v| with K ≈ 1.64676.
- **Degenerate inputs:**
  - ix = iy = 0: omag = 0, oangle within tolerance of 0.
  - ix < 0, iy = 0: oangle within tolerance of 0x400000.
- **Valid pipeline:** ivalid travels through the stages as a valid bit alongside the data. Data registers load regardless of valid.
- **Accuracy:** |oangle error| ≤ 64 LSB and |omag error| ≤ 16 LSB versus ideal, for ITERATIONS = 16.

## Timing
- Latency from a sample with ivalid=1 to its ovalid pulse:
  - ITERATIONS+1 enabled clocks (17 at default).
  - +1 with gain compensation.
- Throughput: one sample per enabled clock; no backpressure and no ready signal.
- inCS=1 freezes every stage, including the valid bits and the outputs.
  - Latency counts enabled clocks only.
  - Samples presented while inCS=1 are dropped.
- ireset=1 at a clock edge clears all valid bits and data registers to 0.
  - After reset: ovalid=0, omag=0, oangle=0.
  - ireset has priority over inCS.
  - Samples in flight at reset are discarded and never produce ovalid.
- The outputs are registered. ovalid is high for exactly one enabled cycle per sample, and omag/oangle are valid while ovalid=1.

## Configuration
- Macro: CORDIC_VECTOR_GAIN_COMP_EN.
- **Defined:**
  - One extra registered stage computes omag = (x_final · K_INV) >> 20, with K_INV = 636751 (0.607253 in Q0.20).
  - omag then equals |v| within tolerance, and omag[20] = 0.
  - oangle is delayed one cycle to stay aligned with omag.
  - Latency = ITERATIONS+2.
- **Undefined:** no multiplier; the output carries gain K; latency = ITERATIONS+1.

## Structure
- Shared package cordic_pkg holds:
  - ATAN[0..15]: the 23-bit arctangent table, identical to the rotation CORDIC table (ATAN[0] = 0x100000).
  - K_INV.
  - Width constants XY_W = 22, Z_W = 23, ANG_PI = 0x400000.
- Sub-module cordic_vector_stage implements one registered iteration.
  - Ports: iclk, ireset, inCS, ivalid, shift amount, atan constant, x, y, z in/out, ovalid.
  - The top level instantiates ITERATIONS copies in a generate loop, plus the pre-rotation stage and the optional gain stage.

## Test plan
- **Reset:** hold ireset 2 cycles with ivalid=1.
  - ovalid=0, omag=0 and oangle=0 during and after reset.
  - No output results from samples applied during reset.
- **Axes:**
  - ix=100000, iy=0: ovalid exactly 17 cycles later; omag=164676±16; oangle=0±64.
  - ix=0, iy=100000: oangle=0x200000±64.
  - With the macro defined: omag=100000±16 and latency 18.
- **Third quadrant and extremes:**
  - ix=−100000, iy=−100000: oangle=0x500000±64 (−3π/4); omag=232886±16.
  - ix=−524288, iy=0: oangle=0x400000±64; omag=863376±16.
- **Streaming:**
  - 32 back-to-back random samples, with ivalid low every 5th cycle.
  - Output ovalid pattern equals the input pattern delayed by the latency.
  - Every result matches the reference model within tolerance, in order.
- **Stall:** inCS=1 for 5 cycles mid-stream.
  - Outputs and ovalid are frozen during the stall.
  - Inputs presented during the stall are dropped.
  - Remaining results emerge 5 cycles late and are otherwise unchanged.
- **Reset mid-flight:** ireset for 1 cycle while 10 samples are in flight.
  - None of the 10 produce ovalid.
  - A new sample presented the next cycle emerges after the normal latency.
